// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning stage.
package btn_pkg;

    localparam int unsigned BTN_PAUSE  = 0;
    localparam int unsigned BTN_FASTER = 1;
    localparam int unsigned BTN_SLOWER = 2;

    localparam int unsigned DEF_NUM_BTN           = 3;
    localparam int unsigned DEF_DEBOUNCE_BITS     = 18;
    localparam int unsigned DEF_REPEAT_DELAY_BITS = 22;
    localparam int unsigned DEF_REPEAT_RATE_BITS  = 20;

    typedef enum logic [1:0] {
        REP_IDLE  = 2'd0,
        REP_DELAY = 2'd1,
        REP_RATE  = 2'd2
    } rep_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, saturating debounce counter, edge pulses.
// Auto-repeat of press pulses while held is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_BITS     = DEF_DEBOUNCE_BITS,
    parameter int unsigned REPEAT_DELAY_BITS = DEF_REPEAT_DELAY_BITS,
    parameter int unsigned REPEAT_RATE_BITS  = DEF_REPEAT_RATE_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    logic                     sync_q1;
    logic                     sync_q2;
    logic [DEBOUNCE_BITS-1:0] db_cnt;
    logic                     flip_c;
    logic                     rise_c;
    logic                     fall_c;
    logic                     rep_fire_c;

    // The level only flips after the counter has saturated on a disagreeing input
    assign flip_c = (sync_q2 != level) && (db_cnt == '1);
    assign rise_c = flip_c & sync_q2;
    assign fall_c = flip_c & ~sync_q2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1       <= 1'b0;
            sync_q2       <= 1'b0;
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q1       <= btn_raw;
            sync_q2       <= sync_q1;
            press_pulse   <= rise_c | rep_fire_c;
            release_pulse <= fall_c;
            if (sync_q2 == level) begin
                db_cnt <= '0;
            end else if (flip_c) begin
                level  <= sync_q2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_W =
        (REPEAT_DELAY_BITS > REPEAT_RATE_BITS) ? REPEAT_DELAY_BITS : REPEAT_RATE_BITS;
    localparam logic [REP_W-1:0] DLY_LAST = {REP_W{1'b1}} >> (REP_W - REPEAT_DELAY_BITS);
    localparam logic [REP_W-1:0] RATE_LAST = {REP_W{1'b1}} >> (REP_W - REPEAT_RATE_BITS);

    rep_state_e       state;
    rep_state_e       state_nxt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= REP_IDLE;
            rep_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rep_cnt <= rep_cnt_nxt;
        end
    end

    // A debounced release always takes priority over a coincident terminal count
    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = rep_cnt;
        rep_fire_c  = 1'b0;
        case (state)
            REP_IDLE: begin
                if (rise_c) begin
                    state_nxt   = REP_DELAY;
                    rep_cnt_nxt = '0;
                end
            end
            REP_DELAY: begin
                if (fall_c) begin
                    state_nxt = REP_IDLE;
                end else if (rep_cnt == DLY_LAST) begin
                    rep_fire_c  = 1'b1;
                    rep_cnt_nxt = '0;
                    state_nxt   = REP_RATE;
                end else begin
                    rep_cnt_nxt = rep_cnt + REP_W'(1);
                end
            end
            REP_RATE: begin
                if (fall_c) begin
                    state_nxt = REP_IDLE;
                end else if (rep_cnt == RATE_LAST) begin
                    rep_fire_c  = 1'b1;
                    rep_cnt_nxt = '0;
                end else begin
                    rep_cnt_nxt = rep_cnt + REP_W'(1);
                end
            end
            default: state_nxt = REP_IDLE;
        endcase
    end
`else
    logic [31:0] rep_cfg_unused;
    assign rep_cfg_unused = 32'(REPEAT_DELAY_BITS + REPEAT_RATE_BITS);
    assign rep_fire_c     = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button input conditioning for the LED bargraph: NUM_BTN independent channels.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN           = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_BITS     = DEF_DEBOUNCE_BITS,
    parameter int unsigned REPEAT_DELAY_BITS = DEF_REPEAT_DELAY_BITS,
    parameter int unsigned REPEAT_RATE_BITS  = DEF_REPEAT_RATE_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_BITS     (DEBOUNCE_BITS),
            .REPEAT_DELAY_BITS (REPEAT_DELAY_BITS),
            .REPEAT_RATE_BITS  (REPEAT_RATE_BITS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_raw       (btn_i[i]),
            .level         (btn_level_o[i]),
            .press_pulse   (btn_press_o[i]),
            .release_pulse (btn_release_o[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat counters.
module tb_btn_conditioner;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] btn_i;
    logic [2:0] btn_level_o;
    logic [2:0] btn_press_o;
    logic [2:0] btn_release_o;

    int n_vec;
    int n_err;

    btn_conditioner #(
        .NUM_BTN           (3),
        .DEBOUNCE_BITS     (4),
        .REPEAT_DELAY_BITS (5),
        .REPEAT_RATE_BITS  (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_i         (btn_i),
        .btn_level_o   (btn_level_o),
        .btn_press_o   (btn_press_o),
        .btn_release_o (btn_release_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock, then sample/drive 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic [2:0] lvl,
                           input logic [2:0] prs, input logic [2:0] rls);
        chk({tag, " level"}, k, btn_level_o, lvl);
        chk({tag, " press"}, k, btn_press_o, prs);
        chk({tag, " release"}, k, btn_release_o, rls);
    endtask

    initial begin
        logic [2:0] exp_p;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        btn_i = 3'b000;

        // Reset: everything quiet
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_all("reset", k, 3'b000, 3'b000, 3'b000);
        end
        rst_n = 1'b1;
        step();

        // Clean press on channel 1: level and press pulse on the 18th edge
        btn_i = 3'b010;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_all("press1", k, (k >= 18) ? 3'b010 : 3'b000,
                    (k == 18) ? 3'b010 : 3'b000, 3'b000);
        end

        // Glitches on channel 0 of 10 and 15 cycles produce nothing
        for (int g = 0; g < 2; g++) begin
            btn_i = 3'b011;
            for (int k = 1; k <= ((g == 0) ? 10 : 15); k++) begin
                step();
                chk_all("glitch_hi", k, 3'b010, 3'b000, 3'b000);
            end
            btn_i = 3'b010;
            for (int k = 1; k <= 22; k++) begin
                step();
                chk_all("glitch_lo", k, 3'b010, 3'b000, 3'b000);
            end
        end

        // Release channel 1: release pulse and level drop on the 18th edge
        btn_i = 3'b000;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_all("release1", k, (k < 18) ? 3'b010 : 3'b000, 3'b000,
                    (k == 18) ? 3'b010 : 3'b000);
        end

        // Hold channel 2 for 80 cycles; repeats at +32,+40..+72 after the press,
        // and the +80 terminal count coincides with the release and is suppressed
        btn_i = 3'b100;
        for (int k = 1; k <= 110; k++) begin
            if (k == 81) btn_i = 3'b000;
            step();
            exp_p = 3'b000;
            if (k == 18) exp_p = 3'b100;
            if (AR && k >= 50 && k <= 90 && ((k - 50) % 8) == 0) exp_p = 3'b100;
            chk_all("hold2", k, (k >= 18 && k < 98) ? 3'b100 : 3'b000, exp_p,
                    (k == 98) ? 3'b100 : 3'b000);
        end

        // Reset while channel 0 is held, then a fresh press after full debounce
        btn_i = 3'b001;
        for (int k = 1; k <= 25; k++) begin
            step();
            chk_all("prehold0", k, (k >= 18) ? 3'b001 : 3'b000,
                    (k == 18) ? 3'b001 : 3'b000, 3'b000);
        end
        rst_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_all("midreset", k, 3'b000, 3'b000, 3'b000);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_all("postreset", k, (k >= 18) ? 3'b001 : 3'b000,
                    (k == 18) ? 3'b001 : 3'b000, 3'b000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
